tx_burst_scheduler: RTL and testbench

TX_BURST_SCHEDULER -- requirements
Module: tx_burst_scheduler

---
 rtl/tx_burst_scheduler.sv | 139 +++++++++++++
 tb/tb_tx_burst_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_scheduler.sv
// TDMA slot scheduler: fires one burst per enabled slot and tracks missed slots.
// Define TX_SCHED_WATCHDOG_EN to build the ACTIVE-time watchdog that drives fault.
module tx_burst_scheduler #(
  parameter int unsigned CLOCKS_PER_SLOT  = 2048,
  parameter int unsigned SLOTS_PER_FRAME  = 8,
  parameter int unsigned MAX_BURST_CLOCKS = 1536
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  slot_mask,
  input  logic        slot_mask_load,
  input  logic        is_armed,
  input  logic        iq_valid,
  output logic        fire_burst,
  output logic [2:0]  slot_index,
  output logic [15:0] frame_count,
  output logic [7:0]  missed_count,
  output logic [1:0]  sched_state,
  output logic        fault
);

  localparam int unsigned TW = (CLOCKS_PER_SLOT > 1) ? $clog2(CLOCKS_PER_SLOT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLOCKS_PER_SLOT - 1);
  localparam logic [2:0]    INDEX_LAST = 3'(SLOTS_PER_FRAME - 1);
  localparam logic [7:0]    SLOT_VALID = 8'((1 << SLOTS_PER_FRAME) - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_FIRE   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic [TW-1:0] slot_timer;
  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [7:0]    pending_mask;
  logic [7:0]    active_mask;
  logic [7:0]    mask_in;
  logic          timer_wrap;
  logic          frame_wrap;
  logic          slot_start;
  logic          miss_event;
  logic          wd_trip;

  assign mask_in     = slot_mask & SLOT_VALID;
  assign timer_wrap  = (slot_timer == TIMER_LAST);
  assign frame_wrap  = timer_wrap && (slot_index == INDEX_LAST);
  assign slot_start  = (state == S_WAIT) && (slot_timer == '0) && active_mask[slot_index];
  assign miss_event  = enable && ((slot_start && !is_armed) ||
                                  ((state == S_FIRE) && !iq_valid && timer_wrap));
  assign sched_state = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot_timer  <= '0;
      slot_index  <= '0;
      frame_count <= '0;
    end else if (!enable) begin
      slot_timer  <= '0;
      slot_index  <= '0;
      frame_count <= '0;
    end else if (timer_wrap) begin
      slot_timer <= '0;
      slot_index <= frame_wrap ? 3'd0 : slot_index + 3'd1;
      if (frame_wrap) frame_count <= frame_count + 16'd1;
    end else begin
      slot_timer <= slot_timer + TW'(1);
    end
  end

  // A load landing on the frame wrap bypasses pending_mask so it applies immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_mask <= '0;
      active_mask  <= '0;
    end else begin
      if (slot_mask_load) pending_mask <= mask_in;
      if (enable && frame_wrap) active_mask <= slot_mask_load ? mask_in : pending_mask;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_WAIT;
      S_WAIT:   if (slot_start && is_armed) state_next = S_FIRE;
      S_FIRE:   if (iq_valid) state_next = S_ACTIVE;
                else if (timer_wrap) state_next = S_WAIT;
      S_ACTIVE: if (!iq_valid || wd_trip) state_next = S_WAIT;
    endcase
    if (!enable) state_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      fire_burst   <= 1'b0;
      missed_count <= '0;
    end else begin
      state      <= state_next;
      fire_burst <= enable && slot_start && is_armed;
      if (miss_event && (missed_count != '1)) missed_count <= missed_count + 8'd1;
    end
  end

`ifdef TX_SCHED_WATCHDOG_EN
  localparam int unsigned WDW = $clog2(MAX_BURST_CLOCKS + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(MAX_BURST_CLOCKS - 1);

  logic [WDW-1:0] wd_count;
  logic           fault_q;

  assign wd_trip = (state == S_ACTIVE) && iq_valid && (wd_count == WD_LAST);
  assign fault   = fault_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_count <= '0;
      fault_q  <= 1'b0;
    end else if (!enable) begin
      wd_count <= '0;
      fault_q  <= 1'b0;
    end else if ((state == S_ACTIVE) && iq_valid) begin
      if (wd_trip) begin
        wd_count <= '0;
        fault_q  <= 1'b1;
      end else begin
        wd_count <= wd_count + WDW'(1);
      end
    end else begin
      wd_count <= '0;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign fault   = 1'b0;
`endif

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed bench for tx_burst_scheduler with a fire-event scoreboard and a burst-generator responder.
module tb_tx_burst_scheduler;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int unsigned CPS = 16;
  localparam int unsigned SPF = 4;
  localparam int unsigned MBC = 10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_FIRE   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  slot_mask = '0;
  logic        slot_mask_load = 1'b0;
  logic        is_armed = 1'b0;
  logic        iq_valid = 1'b0;
  logic        fire_burst;
  logic [2:0]  slot_index;
  logic [15:0] frame_count;
  logic [7:0]  missed_count;
  logic [1:0]  sched_state;
  logic        fault;

  int          checks = 0;
  int          failures = 0;
  logic [18:0] sb[$];
  time         fire_times[$];
  int          burst_len = 0;
  int          gen_left = 0;
  logic        prev_fire = 1'b0;

  always #5 clock = ~clock;

  tx_burst_scheduler #(
    .CLOCKS_PER_SLOT (CPS),
    .SLOTS_PER_FRAME (SPF),
    .MAX_BURST_CLOCKS(MBC)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .slot_mask     (slot_mask),
    .slot_mask_load(slot_mask_load),
    .is_armed      (is_armed),
    .iq_valid      (iq_valid),
    .fire_burst    (fire_burst),
    .slot_index    (slot_index),
    .frame_count   (frame_count),
    .missed_count  (missed_count),
    .sched_state   (sched_state),
    .fault         (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    slot_mask_load = 1'b0;
    is_armed = 1'b0;
    burst_len = 0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic load(input logic [7:0] m);
    slot_mask = m;
    slot_mask_load = 1'b1;
    tick(1);
    slot_mask_load = 1'b0;
  endtask

  task automatic expect_fire(input int unsigned frame, input int unsigned slot);
    sb.push_back({16'(frame), 3'(slot)});
  endtask

  // Scoreboard consumer plus a burst generator that raises iq_valid for burst_len clocks per fire.
  always @(negedge clock) begin
    logic [18:0] exp_ev;
    if (fire_burst === 1'b1) begin
      fire_times.push_back($time);
      check("fire_single_clock", 32'(prev_fire), 32'd0);
      if (sb.size() == 0) begin
        check("fire_unexpected", 32'({frame_count, slot_index}), 32'hFFFF_FFFF);
      end else begin
        exp_ev = sb.pop_front();
        check("fire_frame_slot", 32'({frame_count, slot_index}), 32'(exp_ev));
      end
    end
    prev_fire = fire_burst;
    if (fire_burst === 1'b1) gen_left = burst_len;
    else if (gen_left > 0) gen_left--;
    iq_valid = (gen_left > 0);
  end

  initial begin
    // Reset values
    tick(2);
    check("rst_fire", 32'(fire_burst), 32'd0);
    check("rst_slot", 32'(slot_index), 32'd0);
    check("rst_frame", 32'(frame_count), 32'd0);
    check("rst_missed", 32'(missed_count), 32'd0);
    check("rst_state", 32'(sched_state), 32'(S_IDLE));
    check("rst_fault", 32'(fault), 32'd0);

    // Mask 0x5: fires in slots 0 and 2 from frame 1 onward, 32 clocks apart
    do_reset();
    load(8'h05);
    is_armed = 1'b1;
    burst_len = 8;
    fire_times.delete();
    expect_fire(1, 0); expect_fire(1, 2); expect_fire(2, 0); expect_fire(2, 2);
    enable = 1'b1;
    tick(192);
    check("A_sb_drained", 32'(sb.size()), 32'd0);
    check("A_missed", 32'(missed_count), 32'd0);
    check("A_frame", 32'(frame_count), 32'd3);
    check("A_fire_count", 32'(fire_times.size()), 32'd4);
    for (int i = 1; i < fire_times.size(); i++)
      check("A_fire_gap", 32'(fire_times[i] - fire_times[i-1]), 32'd320);
    enable = 1'b0;
    tick(1);
    check("A_dis_state", 32'(sched_state), 32'(S_IDLE));
    check("A_dis_slot", 32'(slot_index), 32'd0);
    check("A_dis_frame", 32'(frame_count), 32'd0);

    // Mask 0xF never armed: 8 misses over frames 1-2, then saturation
    do_reset();
    load(8'h0F);
    enable = 1'b1;
    tick(192);
    check("B_missed_8", 32'(missed_count), 32'd8);
    check("B_frame", 32'(frame_count), 32'd3);
    check("B_slot", 32'(slot_index), 32'd0);
    tick(70 * 64);
    check("B_missed_sat", 32'(missed_count), 32'd255);

    // Fire with no iq_valid: FIRE times out at end of slot and counts a miss
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    expect_fire(1, 0);
    enable = 1'b1;
    tick(79);
    check("C_state_fire", 32'(sched_state), 32'(S_FIRE));
    check("C_missed_0", 32'(missed_count), 32'd0);
    tick(1);
    check("C_state_wait", 32'(sched_state), 32'(S_WAIT));
    check("C_missed_1", 32'(missed_count), 32'd1);
    check("C_slot", 32'(slot_index), 32'd1);
    check("C_sb_drained", 32'(sb.size()), 32'd0);

    // Mid-frame load only takes effect at the next frame
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    burst_len = 8;
    expect_fire(1, 0); expect_fire(2, 1);
    enable = 1'b1;
    tick(90);
    load(8'h02);
    tick(101);
    check("D_sb_drained", 32'(sb.size()), 32'd0);

    // Load on the frame-wrap clock applies to the very next frame
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    burst_len = 8;
    expect_fire(1, 0); expect_fire(2, 1);
    enable = 1'b1;
    tick(127);
    load(8'h02);
    tick(64);
    check("E_sb_drained", 32'(sb.size()), 32'd0);
    check("E_frame", 32'(frame_count), 32'd3);

    // enable low drops fire_burst on the same clock
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    expect_fire(1, 0);
    enable = 1'b1;
    tick(65);
    check("G_fire_high", 32'(fire_burst), 32'd1);
    enable = 1'b0;
    tick(1);
    check("G_fire_low", 32'(fire_burst), 32'd0);
    check("G_state", 32'(sched_state), 32'(S_IDLE));
    check("G_frame", 32'(frame_count), 32'd0);

    // Asynchronous reset during a fire pulse; masks cleared afterwards
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    enable = 1'b1;
    tick(65);
    check("F_fire_high", 32'(fire_burst), 32'd1);
    reset_n = 1'b0;
    #1;
    check("F_fire_async", 32'(fire_burst), 32'd0);
    check("F_state_async", 32'(sched_state), 32'(S_IDLE));
    check("F_frame_async", 32'(frame_count), 32'd0);
    check("F_slot_async", 32'(slot_index), 32'd0);
    enable = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("F_idle_until_enable", 32'(sched_state), 32'(S_IDLE));
    enable = 1'b1;
    tick(130);
    check("F_state_wait", 32'(sched_state), 32'(S_WAIT));
    check("F_frame", 32'(frame_count), 32'd2);
    check("F_slot", 32'(slot_index), 32'd0);
    check("F_missed", 32'(missed_count), 32'd0);

    // Watchdog: iq_valid held for 20 clocks
    do_reset();
    load(8'h01);
    is_armed = 1'b1;
    burst_len = 20;
    expect_fire(1, 0);
    enable = 1'b1;
    tick(75);
    check("H_state_active", 32'(sched_state), 32'(S_ACTIVE));
    check("H_fault_pre", 32'(fault), 32'd0);
    tick(1);
`ifdef TX_SCHED_WATCHDOG_EN
    check("H_state_tripped", 32'(sched_state), 32'(S_WAIT));
    check("H_fault_set", 32'(fault), 32'd1);
    tick(15);
    check("H_fault_sticky", 32'(fault), 32'd1);
`else
    check("H_state_still_active", 32'(sched_state), 32'(S_ACTIVE));
    check("H_fault_zero", 32'(fault), 32'd0);
    tick(15);
    check("H_state_done", 32'(sched_state), 32'(S_WAIT));
    check("H_fault_still_zero", 32'(fault), 32'd0);
`endif
    enable = 1'b0;
    tick(1);
    enable = 1'b1;
    check("H_fault_cleared", 32'(fault), 32'd0);
    tick(2);
    check("H_sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
